// File: rtl/sobel_window_buffer_if.sv
// Handshake bundle between the memory read port, the window buffer and the Sobel kernel.
// Input side carries single beats; output side carries a flattened ROWS-beat window plus its address.
// The slave modport is the window buffer's view; the master modport is the surrounding logic's view.
interface sobel_window_buffer_if #(
    parameter int DATA_W = 64,
    parameter int ROWS   = 4,
    parameter int ADDR_W = 24
);
    logic [DATA_W-1:0]      in_data;
    logic                   in_valid;
    logic                   in_ready;
    logic [ROWS*DATA_W-1:0] win_data;
    logic                   win_valid;
    logic                   win_ready;
    logic [ADDR_W-1:0]      win_addr;

    // Beat producer and window consumer side
    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  win_data,
        input  win_valid,
        output win_ready,
        input  win_addr
    );

    // Window buffer side
    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output win_data,
        output win_valid,
        input  win_ready,
        output win_addr
    );
endinterface

// File: rtl/sobel_window_buffer.sv
// Collects ROWS consecutive beats into a shift chain and presents them as one addressed window.
// Latency: window valid 1 clock after the completing beat; frame_done 1 clock after the last window is consumed.
// Backpressure: in_ready drops while a window is held, so beats wait upstream until win_ready consumes it.
module sobel_window_buffer #(
    parameter int DATA_W     = 64,
    parameter int ROWS       = 4,
    parameter int START_ADDR = 0,
    parameter int END_ADDR   = 2097151,
    parameter int ADDR_W     = 24
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  slide_mode,
    sobel_window_buffer_if.slave  bus,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int                CNT_W   = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [CNT_W-1:0]  LAST    = CNT_W'(ROWS - 1);
    localparam logic [ADDR_W-1:0] START_A = ADDR_W'(START_ADDR);
    localparam logic [ADDR_W-1:0] END_A   = ADDR_W'(END_ADDR);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        HOLD = 2'd2
    } stateType;

    stateType state;
    stateType stateNext;

    // Older beats; index 1 is the most recently stored, ROWS-1 the oldest.
    logic [ROWS-1:1][DATA_W-1:0] shiftReg;
    logic [CNT_W-1:0]            fillCnt;
    logic [ROWS*DATA_W-1:0]      winData;
    logic [ADDR_W-1:0]           winAddr;
    logic                        slideLatched;
    logic                        frameDone;

    logic beatAccept;
    logic beatComplete;
    logic winConsume;
    logic lastWindow;

    assign lastWindow = (winAddr == END_A);

    // Next-state and handshake decode
    always_comb begin
        stateNext    = state;
        beatAccept   = 1'b0;
        beatComplete = 1'b0;
        winConsume   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    stateNext = FILL;
                end
            end
            FILL: begin
                if (bus.in_valid) begin
                    beatAccept = 1'b1;
                    if (fillCnt == LAST) begin
                        beatComplete = 1'b1;
                        stateNext    = HOLD;
                    end
                end
            end
            HOLD: begin
                if (bus.win_ready) begin
                    winConsume = 1'b1;
                    stateNext  = lastWindow ? IDLE : FILL;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Shift chain: every accepted beat shifts, including the completing one, so sliding windows line up.
    always_ff @(posedge clk) begin
        if (!reset) begin
            shiftReg <= '0;
        end else if (beatAccept) begin
            for (int k = ROWS - 1; k >= 2; k--) begin
                shiftReg[k] <= shiftReg[k-1];
            end
            shiftReg[1] <= bus.in_data;
        end
    end

    // Window capture: newest beat lands in slice 0, the chain fills slices 1..ROWS-1.
    always_ff @(posedge clk) begin
        if (!reset) begin
            winData <= '0;
        end else if (beatComplete) begin
            winData <= {shiftReg, bus.in_data};
        end
    end

    // Fill counter: counts beats toward a full window; sliding mode keeps it saturated after the first window.
    always_ff @(posedge clk) begin
        if (!reset) begin
            fillCnt <= '0;
        end else if (state == IDLE && start) begin
            fillCnt <= '0;
        end else if (beatAccept && !beatComplete) begin
            fillCnt <= fillCnt + CNT_W'(1);
        end else if (winConsume && !lastWindow && !slideLatched) begin
            fillCnt <= '0;
        end
    end

    // Window address: loaded at frame start, stepped on each consumed window, wrapped after the last.
    always_ff @(posedge clk) begin
        if (!reset) begin
            winAddr <= '0;
        end else if (state == IDLE && start) begin
            winAddr <= START_A;
        end else if (winConsume) begin
            winAddr <= lastWindow ? START_A : winAddr + ADDR_W'(1);
        end
    end

    // Mode latch: slide_mode only matters at the moment a frame starts.
    always_ff @(posedge clk) begin
        if (!reset) begin
            slideLatched <= 1'b0;
        end else if (state == IDLE && start) begin
            slideLatched <= slide_mode;
        end
    end

    // Frame-done pulse lands in the IDLE cycle after the last window, so it never overlaps win_valid.
    always_ff @(posedge clk) begin
        if (!reset) begin
            frameDone <= 1'b0;
        end else begin
            frameDone <= winConsume && lastWindow;
        end
    end

    assign bus.in_ready  = (state == FILL);
    assign bus.win_valid = (state == HOLD);
    assign bus.win_data  = winData;
    assign bus.win_addr  = winAddr;
    assign busy          = (state != IDLE);
    assign frame_done    = frameDone;

endmodule

// File: doc/sobel_window_buffer.md
Name: sobel_window_buffer

Overview:
- Parametrised successor to the Sobel row-buffer stage: collects ROWS consecutive 64-bit memory beats into a shift chain and presents them as one flattened window.
- Adds valid/ready handshaking on both sides and a per-frame window address counter with wrap and frame-done.
- Adds an optional sliding mode: after the first window, each new beat produces a new window.
- Sits between the memory read port and the Sobel kernel.

Parameters:
DATA_W, 64, width of one beat / row
ROWS, 4, rows per window (legal range 2..16)
START_ADDR, 0, window address loaded at frame start
END_ADDR, 2097151, address of the last window in a frame
ADDR_W, 24, width of win_addr

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-low reset (reset==0 at a rising edge resets the block)
start  in  1  one-cycle frame start; honoured only in IDLE
slide_mode  in  1  0 = block mode, 1 = sliding mode; sampled only when start is honoured
in_data  in  DATA_W  input beat
in_valid  in  1  in_data is valid
in_ready  out  1  block accepts a beat this cycle
win_data  out  ROWS*DATA_W  window; slice k = bits [k*DATA_W +: DATA_W]; slice 0 = newest beat, slice ROWS-1 = oldest
win_valid  out  1  win_data and win_addr are valid
win_ready  in  1  downstream consumes the window
win_addr  out  ADDR_W  address of the presented window
busy  out  1  high in any state other than IDLE
frame_done  out  1  one-cycle pulse after the window at END_ADDR is consumed

Behaviour:
Reset:
- Forces IDLE.
- Clears shift chain, fill_cnt, win_data, win_addr, win_valid, frame_done and the latched mode.
- Overrides every other input, including mid-frame.
- in_ready=0 and busy=0 are the reset values.

States: IDLE, FILL, HOLD.
- in_ready = (state==FILL), combinational.
- busy = (state!=IDLE).
- win_valid = (state==HOLD), registered.

IDLE:
- On start=1: latch slide_mode, set win_addr=START_ADDR, set fill_cnt=0, go to FILL.
- in_valid is ignored in IDLE.

FILL: a beat is accepted when in_valid && in_ready.
- Each accepted beat shifts the chain: sreg[k] <= sreg[k-1] for k = ROWS-1..2; sreg[1] <= in_data.
- If fill_cnt < ROWS-1: increment fill_cnt.
- If fill_cnt == ROWS-1 (completing beat):
  - win_data slice 0 <= in_data; slice k <= sreg[k] for k = 1..ROWS-1.
  - Go to HOLD.
  - win_valid rises on the next cycle: latency 1 clock from the completing beat.
- start is ignored while in FILL.

HOLD:
- win_data and win_addr are held stable. in_ready=0, so no beats are lost.
- On win_ready=1, the window is consumed.
- If win_addr==END_ADDR: pulse frame_done for one cycle, go to IDLE, and wrap win_addr to START_ADDR.
- Otherwise win_addr <= win_addr+1 (ADDR_W modulo), then:
  - Block mode: fill_cnt=0, go to FILL. The next window needs ROWS new beats; old chain contents are overwritten.
  - Sliding mode: fill_cnt stays ROWS-1, go to FILL. The next single accepted beat completes a window whose slices 1..ROWS-1 are the previous window's slices 0..ROWS-2.
- The shift chain is always updated on the completing beat, so sliding is consistent.
- start is ignored while in HOLD.

Boundary conditions:
- START_ADDR==END_ADDR: the frame is exactly one window.
- in_valid=0 in FILL: the block stalls with no state change.
- win_ready held high in HOLD: consumed in the first HOLD cycle. Maximum throughput is 1 window per ROWS+1 cycles (block mode) or per 2 cycles (sliding mode).
- win_ready while win_valid=0: ignored.
- slide_mode changing mid-frame: no effect.
- frame_done is never asserted together with win_valid.

Test Plan:
- Block mode, ROWS=4, START_ADDR=0, END_ADDR=1; start, then beats 0x11,0x22,0x33,0x44 with win_ready=1 -> one cycle after 0x44: win_valid=1, win_addr=0, slices0..3 = 0x44,0x33,0x22,0x11; beats 0x55..0x88 -> window slices 0x88,0x77,0x66,0x55 at win_addr=1; frame_done pulses once, busy=0.
- Sliding mode, END_ADDR=2; beats 1,2,3,4,5,6 -> windows {4,3,2,1}@0, {5,4,3,2}@1, {6,5,4,3}@2, then frame_done.
- Backpressure: window presented with win_ready=0 for 5 cycles while in_valid=1 -> in_ready=0 throughout, win_data stable; win_ready=1 -> exactly one address increment; no beat dropped (next window matches the next 4 driven beats).
- Input gaps: in_valid toggled 1,0,0,1,1,0,1 -> window formed only from accepted beats, in correct order.
- Reset (reset=0) asserted in FILL after 2 beats, and separately in HOLD -> next cycle IDLE, win_valid=0, in_ready=0, win_data=0; a fresh start yields correct windows.
- start asserted during FILL/HOLD -> ignored (win_addr, fill_cnt unchanged). Wrap check with ADDR_W=4, START_ADDR=14, END_ADDR=15: second window at address 15, then win_addr wraps to 14.
